// File: rtl/irq_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_arbiter_pkg
// Purpose  : Shared constants and types for the interrupt arbiter: source
//            count, index width, config address map and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package irq_arbiter_pkg;

    localparam int NUM_SRC = 8;
    localparam int ID_W    = 3;

    // Config register map
    localparam logic [1:0] c_ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] c_ADDR_PENDING = 2'd1;
    localparam logic [1:0] c_ADDR_CLAIM   = 2'd2;
    localparam logic [1:0] c_ADDR_STATUS  = 2'd3;

    // Encoding is visible to software through STATUS[1:0]
    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_REQ        = 2'b01,
        ST_WAIT_CLAIM = 2'b10,
        ST_SERVICE    = 2'b11
    } state_e;

endpackage
`default_nettype wire

// File: rtl/irq_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_select
// Purpose  : Combinational round-robin picker. Returns the first set bit of
//            the eligible mask at or after the pointer, wrapping 7 -> 0.
// Ports    : eligible_i - mask of sources that may be selected
//            ptr_i      - index with the highest priority this round
//            valid_o    - at least one eligible source exists
//            idx_o      - selected source index (0 when valid_o = 0)
// Revision : 1.0 - initial release
// ============================================================================
module rr_select
    import irq_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] eligible_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [ID_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest hit is the last
    // assignment and therefore wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        w_cand  = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_cand = ptr_i + k[ID_W-1:0];
            if (eligible_i[w_cand]) begin
                valid_o = 1'b1;
                idx_o   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : irq_arbiter
// Purpose  : 8-source edge-triggered interrupt arbiter with round-robin
//            selection and a claim/complete handshake over a small config
//            register port.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            irq_src       - level interrupt sources (rising edge latched)
//            int_ack       - trap-entry pulse from the exception unit
//            cfg_re/cfg_we - config read/write strobes
//            cfg_addr      - 0 ENABLE, 1 PENDING, 2 CLAIM, 3 STATUS
//            cfg_wdata     - config write data
//            cfg_rdata     - combinational read data (0 when cfg_re = 0)
//            interrupt     - registered interrupt request
//            irq_id        - registered candidate index while interrupt = 1
// Revision : 1.0 - initial release
// ============================================================================
module irq_arbiter
    import irq_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  irq_src,
    input  logic                int_ack,
    input  logic                cfg_re,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    output logic [31:0]         cfg_rdata,
    output logic                interrupt,
    output logic [ID_W-1:0]     irq_id
);

    state_e                state_q, state_d;
    logic [NUM_SRC-1:0]    src_q;
    logic [NUM_SRC-1:0]    pending_q, pending_d;
    logic [NUM_SRC-1:0]    enable_q, enable_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       active_id_q, active_id_d;
    logic [ID_W-1:0]       irq_id_q, irq_id_d;
    logic                  interrupt_q, interrupt_d;

    logic [NUM_SRC-1:0]    w_edge;
    logic [NUM_SRC-1:0]    w_eligible;
    logic [NUM_SRC-1:0]    w_claim_clr;
    logic                  w_sel_valid;
    logic [ID_W-1:0]       w_sel_idx;
    logic                  w_claim_rd;
    logic                  w_claim_wr;
    logic                  w_enable_wr;
    logic                  w_unused_wdata;

    assign w_edge         = irq_src & ~src_q;
    assign w_eligible     = pending_q & enable_q;
    assign w_claim_rd     = cfg_re && (cfg_addr == c_ADDR_CLAIM);
    assign w_claim_wr     = cfg_we && (cfg_addr == c_ADDR_CLAIM);
    assign w_enable_wr    = cfg_we && (cfg_addr == c_ADDR_ENABLE);
    assign w_unused_wdata = ^cfg_wdata[31:8];

    rr_select u_rr_select (
        .eligible_i (w_eligible),
        .ptr_i      (rr_ptr_q),
        .valid_o    (w_sel_valid),
        .idx_o      (w_sel_idx)
    );

    // Next-state and register updates
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        active_id_d = active_id_q;
        w_claim_clr = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_sel_valid) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (int_ack)           state_d = ST_WAIT_CLAIM;
                else if (!w_sel_valid) state_d = ST_IDLE;
            end
            ST_WAIT_CLAIM: begin
                if (w_claim_rd) begin
                    if (w_sel_valid) begin
                        w_claim_clr[w_sel_idx] = 1'b1;
                        rr_ptr_d               = w_sel_idx + 3'd1;
                        active_id_d            = w_sel_idx;
                        state_d                = ST_SERVICE;
                    end else begin
                        // Nothing left to claim: abandon the handshake
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SERVICE: begin
                if (w_claim_wr && (cfg_wdata[3:0] == ({1'b0, active_id_q} + 4'd1)))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh edge on the source being claimed re-arms it
        pending_d   = (pending_q & ~w_claim_clr) | w_edge;
        enable_d    = w_enable_wr ? cfg_wdata[NUM_SRC-1:0] : enable_q;
        interrupt_d = (state_d == ST_REQ);
        irq_id_d    = (state_d == ST_REQ) ? w_sel_idx : irq_id_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            rr_ptr_q    <= '0;
            active_id_q <= '0;
            irq_id_q    <= '0;
            interrupt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= irq_src;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            rr_ptr_q    <= rr_ptr_d;
            active_id_q <= active_id_d;
            irq_id_q    <= irq_id_d;
            interrupt_q <= interrupt_d;
        end
    end

    // Read mux; CLAIM only returns an id when a claim would actually succeed
    always_comb begin
        cfg_rdata = '0;
        if (cfg_re) begin
            case (cfg_addr)
                c_ADDR_ENABLE:  cfg_rdata[NUM_SRC-1:0] = enable_q;
                c_ADDR_PENDING: cfg_rdata[NUM_SRC-1:0] = pending_q;
                c_ADDR_CLAIM: begin
                    if ((state_q == ST_WAIT_CLAIM) && w_sel_valid)
                        cfg_rdata[ID_W:0] = {1'b0, w_sel_idx} + 4'd1;
                end
                c_ADDR_STATUS:  cfg_rdata[7:0] = {active_id_q, rr_ptr_q, state_q};
                default: ;
            endcase
        end
    end

    assign interrupt = interrupt_q;
    assign irq_id    = irq_id_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_arbiter
// Purpose  : Self-checking bench for irq_arbiter: directed scenarios plus a
//            randomized run compared against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_src;
    logic        int_ack;
    logic        cfg_re;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        interrupt;
    logic [2:0]  irq_id;

    always #5 clk = ~clk;

    irq_arbiter u_dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .int_ack   (int_ack),
        .cfg_re    (cfg_re),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .interrupt (interrupt),
        .irq_id    (irq_id)
    );

    int total = 0;
    int bad   = 0;

    // Stimulus for the next cycle
    logic        t_rst   = 1'b0;
    logic [7:0]  t_src   = 8'h00;
    logic        t_ack   = 1'b0;
    logic        t_re    = 1'b0;
    logic        t_we    = 1'b0;
    logic [1:0]  t_addr  = 2'd0;
    logic [31:0] t_wdata = 32'd0;
    logic [31:0] rd_dut;
    logic [31:0] rd_exp;

    // Reference model (state numbers as seen in STATUS: 0 idle, 1 req,
    // 2 waiting for claim, 3 in service)
    int          m_state = 0;
    int          m_ptr   = 0;
    int          m_act   = 0;
    int          m_id    = 0;
    logic [7:0]  m_pend  = 8'h00;
    logic [7:0]  m_en    = 8'h00;
    logic [7:0]  m_prev  = 8'h00;
    logic        m_int   = 1'b0;

    function automatic int pick(input logic [7:0] elig, input int ptr);
        for (int k = 0; k < 8; k++)
            if (elig[(ptr + k) % 8]) return (ptr + k) % 8;
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input logic re, input logic [1:0] addr);
        int p;
        p = pick(m_pend & m_en, m_ptr);
        if (!re) return 32'd0;
        case (addr)
            2'd0:    return {24'd0, m_en};
            2'd1:    return {24'd0, m_pend};
            2'd2:    return (m_state == 2 && p >= 0) ? 32'(p + 1) : 32'd0;
            default: return {24'd0, m_act[2:0], m_ptr[2:0], m_state[1:0]};
        endcase
    endfunction

    task automatic model_update();
        int         p;
        int         ns;
        logic [7:0] np;
        if (t_rst) begin
            m_state = 0; m_ptr = 0; m_act = 0; m_id = 0;
            m_pend = 8'h00; m_en = 8'h00; m_prev = 8'h00; m_int = 1'b0;
            return;
        end
        p  = pick(m_pend & m_en, m_ptr);
        ns = m_state;
        np = m_pend;
        case (m_state)
            0: if (p >= 0) ns = 1;
            1: begin
                if (t_ack) ns = 2;
                else if (p < 0) ns = 0;
            end
            2: if (t_re && t_addr == 2'd2) begin
                if (p >= 0) begin
                    np[p] = 1'b0; m_ptr = (p + 1) % 8; m_act = p; ns = 3;
                end else ns = 0;
            end
            default: if (t_we && t_addr == 2'd2 && t_wdata[3:0] == 4'(m_act + 1)) ns = 0;
        endcase
        m_pend = np | (t_src & ~m_prev);
        if (t_we && t_addr == 2'd0) m_en = t_wdata[7:0];
        m_prev  = t_src;
        m_state = ns;
        m_int   = (ns == 1);
        if (ns == 1) m_id = p;
    endtask

    // One clock cycle: drive, capture read data, advance model, land on negedge
    task automatic step();
        rst = t_rst; irq_src = t_src; int_ack = t_ack;
        cfg_re = t_re; cfg_we = t_we; cfg_addr = t_addr; cfg_wdata = t_wdata;
        #1;
        rd_dut = cfg_rdata;
        rd_exp = model_read(t_re, t_addr);
        @(posedge clk);
        model_update();
        @(negedge clk);
        t_rst = 1'b0; t_ack = 1'b0; t_re = 1'b0; t_we = 1'b0; t_addr = 2'd0; t_wdata = 32'd0;
    endtask

    task automatic cfg_read(input logic [1:0] addr);
        t_re = 1'b1; t_addr = addr; step();
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        t_we = 1'b1; t_addr = addr; t_wdata = data; step();
    endtask

    task automatic do_reset();
        t_rst = 1'b1; t_src = 8'h00; step();
    endtask

    task automatic wait_int(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (interrupt === 1'b1) begin ok = 1'b1; break; end
            step();
        end
        if (interrupt === 1'b1) ok = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(); do_reset();
        total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL reset_int: got %b want 0", interrupt); end
        total++; if (irq_id !== 3'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", irq_id); end
        for (int a = 0; a < 4; a++) begin
            cfg_read(2'(a));
            total++;
            if (rd_dut !== 32'd0) begin bad++; $display("FAIL reset_reg%0d: got %h want 0", a, rd_dut); end
        end
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        cfg_write(2'd0, 32'h0000_0005);
        t_src = 8'h04; step();
        wait_int(2, ok);
        total++; if (!ok) begin bad++; $display("FAIL s1_int: got %b want 1", interrupt); end
        total++; if (irq_id !== 3'd2) begin bad++; $display("FAIL s1_id: got %0d want 2", irq_id); end
        t_ack = 1'b1; step();
        total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL s1_ack: got %b want 0", interrupt); end
        cfg_read(2'd2);
        total++; if (rd_dut !== 32'd3) begin bad++; $display("FAIL s1_claim: got %0d want 3", rd_dut); end
        cfg_write(2'd2, 32'd3);
        cfg_read(2'd3);
        total++; if (rd_dut !== 32'h4C) begin bad++; $display("FAIL s1_status: got %h want 4c", rd_dut); end
        t_src = 8'h00; step();
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_ids [3] = '{2, 6, 7};
        do_reset();
        cfg_write(2'd0, 32'h0000_00FF);
        t_src = 8'h62; step();
        t_src = 8'h00;
        for (int i = 0; i < 3; i++) begin
            wait_int(4, ok);
            total++; if (!ok) begin bad++; $display("FAIL rr_wait%0d: got %b want 1", i, interrupt); end
            t_ack = 1'b1; step();
            cfg_read(2'd2);
            total++;
            if (rd_dut !== 32'(exp_ids[i])) begin bad++; $display("FAIL rr_claim%0d: got %0d want %0d", i, rd_dut, exp_ids[i]); end
            cfg_write(2'd2, 32'(exp_ids[i]));
        end
    endtask

    task automatic test_service_block();
        bit ok;
        do_reset();
        cfg_write(2'd0, 32'h0000_00FF);
        t_src = 8'h04; step();
        t_src = 8'h00;
        wait_int(3, ok);
        t_ack = 1'b1; step();
        cfg_read(2'd2);
        total++; if (rd_dut !== 32'd3) begin bad++; $display("FAIL svc_claim: got %0d want 3", rd_dut); end
        t_src = 8'h08; step();
        t_src = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL svc_quiet%0d: got %b want 0", i, interrupt); end
        end
        cfg_write(2'd2, 32'd5);
        cfg_read(2'd3);
        total++; if (rd_dut[1:0] !== 2'd3) begin bad++; $display("FAIL svc_wrong_id: state got %0d want 3", rd_dut[1:0]); end
        total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL svc_wrong_int: got %b want 0", interrupt); end
        cfg_write(2'd2, 32'd3);
        cfg_read(2'd3);
        total++; if (rd_dut[1:0] !== 2'd0) begin bad++; $display("FAIL svc_complete: state got %0d want 0", rd_dut[1:0]); end
        wait_int(3, ok);
        total++; if (!ok) begin bad++; $display("FAIL svc_next_int: got %b want 1", interrupt); end
        total++; if (irq_id !== 3'd3) begin bad++; $display("FAIL svc_next_id: got %0d want 3", irq_id); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        do_reset();
        cfg_write(2'd0, 32'h0000_0010);
        t_src = 8'h10; step();
        t_src = 8'h00;
        wait_int(3, ok);
        total++; if (!ok) begin bad++; $display("FAIL drop_int: got %b want 1", interrupt); end
        cfg_write(2'd0, 32'h0000_0000);
        step();
        total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL drop_deassert: got %b want 0", interrupt); end
        cfg_read(2'd1);
        total++; if (rd_dut !== 32'h10) begin bad++; $display("FAIL drop_pending: got %h want 10", rd_dut); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        cfg_write(2'd0, 32'h0000_0010);
        t_src = 8'h10; step();
        t_src = 8'h00;
        wait_int(3, ok);
        t_ack = 1'b1; step();
        t_src = 8'h10; cfg_read(2'd2);
        total++; if (rd_dut !== 32'd5) begin bad++; $display("FAIL b2b_claim: got %0d want 5", rd_dut); end
        cfg_read(2'd1);
        total++; if (rd_dut !== 32'h10) begin bad++; $display("FAIL b2b_pending: got %h want 10", rd_dut); end
        cfg_read(2'd3);
        total++; if (rd_dut !== 32'h97) begin bad++; $display("FAIL b2b_status: got %h want 97", rd_dut); end
        do_reset();
        total++; if (interrupt !== 1'b0 || irq_id !== 3'd0) begin bad++; $display("FAIL b2b_rst_out: got %b/%0d want 0/0", interrupt, irq_id); end
        for (int a = 0; a < 4; a++) begin
            if (a == 2) continue;
            cfg_read(2'(a));
            total++;
            if (rd_dut !== 32'd0) begin bad++; $display("FAIL b2b_rst_reg%0d: got %h want 0", a, rd_dut); end
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) t_src = 8'($urandom);
            t_rst = ($urandom_range(0, 299) == 0);
            t_ack = m_int ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 9);
            if (m_state == 2 && r < 6) begin
                t_re = 1'b1; t_addr = 2'd2;
            end else if (m_state == 3 && r < 5) begin
                t_we = 1'b1; t_addr = 2'd2;
                t_wdata = (r < 4) ? 32'(m_act + 1) : 32'($urandom_range(0, 15));
            end else if (r == 6) begin
                t_re = 1'b1; t_addr = 2'($urandom_range(0, 3));
            end else if (r == 7) begin
                t_we = 1'b1; t_addr = 2'($urandom_range(0, 3)); t_wdata = $urandom;
            end
            step();
            total++;
            if (rd_dut !== rd_exp) begin bad++; $display("FAIL rnd_rdata@%0d: got %h want %h", n, rd_dut, rd_exp); end
            total++;
            if (interrupt !== m_int) begin bad++; $display("FAIL rnd_int@%0d: got %b want %b", n, interrupt, m_int); end
            if (m_int) begin
                total++;
                if (irq_id !== 3'(m_id)) begin bad++; $display("FAIL rnd_id@%0d: got %0d want %0d", n, irq_id, m_id); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; irq_src = 8'h00; int_ack = 1'b0;
        cfg_re = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_round_robin();
        test_service_block();
        test_enable_drop();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
- REQ-001: The block SHALL have exactly one clock and one reset: `clk` (input, 1, rising edge) and `rst` (input, 1). Reset is synchronous and active-high.
- REQ-002: `irq_src` SHALL be an input, 8 bits wide: level interrupt sources; bit i is source i.
- REQ-003: `int_ack` SHALL be an input, 1 bit: one-cycle pulse from the exception unit when trap entry for an interrupt starts.
- REQ-004: `cfg_re` / `cfg_we` SHALL be inputs, 1 bit each: config read and write strobes; they are never both 1 in the same cycle.
- REQ-005: `cfg_addr` SHALL be an input, 2 bits: 0 ENABLE (rw), 1 PENDING (ro), 2 CLAIM (read = claim, write = complete), 3 STATUS (ro).
- REQ-006: `cfg_wdata` SHALL be an input, 32 bits: write data.
- REQ-007: `cfg_rdata` SHALL be an output, 32 bits: combinational read data for `cfg_addr`; 0 when `cfg_re`=0.
- REQ-008: `interrupt` SHALL be an output, 1 bit, registered: drives the exception unit's interrupt input.
- REQ-009: `irq_id` SHALL be an output, 3 bits, registered: the candidate source index while `interrupt`=1.

Function
- REQ-010: Edge detection and pending:
  - Each source SHALL be rising-edge detected against a registered copy of `irq_src`.
  - An edge SHALL set PENDING[i] whether or not ENABLE[i] is set.
- REQ-011: Eligible set SHALL be PENDING & ENABLE. Selection SHALL be round-robin: first eligible index at or after `rr_ptr`, wrapping 7 to 0.
- REQ-012: State machine SHALL have four states: IDLE, REQ, WAIT_CLAIM, SERVICE.
- REQ-013: IDLE -> REQ on the cycle after eligible becomes nonzero. `interrupt`=1 and `irq_id` is valid from REQ entry.
- REQ-014: REQ -> WAIT_CLAIM on `int_ack`. `interrupt` SHALL be 0 from the next cycle. If eligible becomes 0 before `int_ack`, REQ -> IDLE and `interrupt`=0 next cycle.
- REQ-015: In WAIT_CLAIM, a CLAIM read SHALL:
  - return {29'b0, id} + 1 for the selected source;
  - clear PENDING[id] at the clock edge;
  - set `rr_ptr` = (id+1) mod 8, record `active_id` = id, and go to SERVICE.
- REQ-016: A CLAIM read with eligible = 0 SHALL return 0, change no state, and WAIT_CLAIM -> IDLE.
- REQ-017: A CLAIM read in IDLE, REQ or SERVICE SHALL return 0 and have no side effects.
- REQ-018: In SERVICE, a CLAIM write with `cfg_wdata[3:0]` = `active_id`+1 SHALL complete: SERVICE -> IDLE. Any other value SHALL be ignored.
- REQ-019: While in WAIT_CLAIM or SERVICE, no new `interrupt` SHALL be raised. Pending bits keep accumulating.
- REQ-020: If an edge on source i coincides with the claim clearing PENDING[i], the set SHALL win and PENDING[i] stays 1.
- REQ-021: ENABLE writes SHALL take effect from the next cycle. Bits [31:8] are ignored on write and read as 0.
- REQ-022: STATUS SHALL read as {24'b0, active_id[2:0], rr_ptr[2:0], state[1:0]}.
- REQ-023: An `int_ack` outside REQ SHALL be ignored.

Reset
- REQ-024: On `rst`=1 at a rising edge, the following SHALL all be 0 and state SHALL be IDLE:
  - `interrupt`, `irq_id`
  - PENDING, ENABLE
  - `rr_ptr`, `active_id`
  - the edge-detect register
- REQ-025: Reset SHALL override any concurrent edge, config access or `int_ack`. This includes reset arriving mid-service: no completion is required afterwards.
- REQ-026: `cfg_rdata` is combinational and needs no reset value.

Structure
- REQ-027: A shared package SHALL hold:
  - state encoding: IDLE=2'b00, REQ=2'b01, WAIT_CLAIM=2'b10, SERVICE=2'b11;
  - config address constants;
  - source count NUM_SRC=8.
- REQ-028: One sub-module, `rr_select`, SHALL be purely combinational. It takes an 8-bit eligible mask and a 3-bit pointer and outputs a valid flag and a 3-bit index.

Verification
- REQ-029: The bench SHALL cover these directed scenarios:
  1. ENABLE=0x05, then edge on src2 → `interrupt`=1 and `irq_id`=2 within 2 cycles. `int_ack` → `interrupt`=0. CLAIM read returns 3. Complete write 3 → STATUS state=IDLE.
  2. ENABLE=0xFF, edges on src1, src5, src6 in the same cycle, `rr_ptr`=0 → successive claims return 2, 6, 7.
  3. In SERVICE, edge on src3 with ENABLE[3]=1 → no `interrupt` until a correct complete. Then `interrupt`=1 and `irq_id`=3.
  4. Complete write of a wrong id (e.g. 5 while `active_id`=2) → state stays SERVICE. A correct write of 3 returns to IDLE.
  5. In REQ, clear ENABLE before `int_ack` → `interrupt`=0 next cycle. PENDING still shows the bit.
  6. Claim of src4 in the same cycle as a new src4 edge → PENDING[4] remains 1. `rst` during SERVICE → all registers 0 and `interrupt`=0.
